// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard/forwarding controller.
// The datapath (master) drives D/E stage fields; the controller (slave) returns stall/forward selects.
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] rsD;
    logic [REG_W-1:0] rtD;
    logic [REG_W-1:0] rsE;
    logic [REG_W-1:0] rtE;
    logic             WRITEREGE;
    logic             MEMTOREGE;
    logic [REG_W-1:0] WRITEADDRE;
    logic             STALLF;
    logic             STALLD;
    logic             FLUSHE;
    logic [1:0]       FORWARDAE;
    logic [1:0]       FORWARDBE;
    logic [CNT_W-1:0] STALLCNT;

    modport master (
        output rsD, rtD, rsE, rtE, WRITEREGE, MEMTOREGE, WRITEADDRE,
        input  STALLF, STALLD, FLUSHE, FORWARDAE, FORWARDBE, STALLCNT
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, WRITEREGE, MEMTOREGE, WRITEADDRE,
        output STALLF, STALLD, FLUSHE, FORWARDAE, FORWARDBE, STALLCNT
    );
endinterface

// File: rtl/hazard_unit.sv
// Load-use stall and EX operand forwarding for the 5-stage pipeline, with a
// private M/W shadow of the write-back destination and a saturating stall counter.

module hazard_fwd_sel #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             wrM,
    input  logic             memM,
    input  logic [REG_W-1:0] addrM,
    input  logic             wrW,
    input  logic [REG_W-1:0] addrW,
    output logic [1:0]       fwd
);
    // A load in M has no data yet, so only ALU results forward from M.
    always_comb begin
        fwd = 2'b00;
        if (wrM && !memM && (addrM != '0) && (addrM == src))
            fwd = 2'b10;
        else if (wrW && (addrW != '0) && (addrW == src))
            fwd = 2'b01;
    end
endmodule

module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic         CLK,
    input logic         RST,
    hazard_unit_if.slave bus
);
    typedef struct packed {
        logic             wr;
        logic             mem;
        logic [REG_W-1:0] addr;
    } stg_t;

    typedef enum logic {RUN, BUBBLE} state_t;

    stg_t             stgM;
    logic             writeregW;
    logic [REG_W-1:0] addrW;
    state_t           state_q, state_d;
    logic             lwstall;
    logic [CNT_W-1:0] cnt;

    logic [1:0][REG_W-1:0] src;
    logic [1:0][1:0]       fwd;

    assign lwstall = bus.MEMTOREGE & bus.WRITEREGE & (bus.WRITEADDRE != '0) &
                     ((bus.WRITEADDRE == bus.rsD) | (bus.WRITEADDRE == bus.rtD));

    assign bus.STALLF = lwstall;
    assign bus.STALLD = lwstall;
    assign bus.FLUSHE = lwstall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stgM      <= '0;
            writeregW <= 1'b0;
            addrW     <= '0;
        end else begin
            stgM      <= '{wr: bus.WRITEREGE, mem: bus.MEMTOREGE, addr: bus.WRITEADDRE};
            writeregW <= stgM.wr;
            addrW     <= stgM.addr;
        end
    end

    assign src[0] = bus.rsE;
    assign src[1] = bus.rtE;

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
            .src   (src[g]),
            .wrM   (stgM.wr),
            .memM  (stgM.mem),
            .addrM (stgM.addr),
            .wrW   (writeregW),
            .addrW (addrW),
            .fwd   (fwd[g])
        );
    end

    assign bus.FORWARDAE = fwd[0];
    assign bus.FORWARDBE = fwd[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (lwstall) state_d = BUBBLE;
            BUBBLE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            cnt <= '0;
        else if (lwstall && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign bus.STALLCNT = cnt;

`ifndef SYNTHESIS
    // The cleared ID/EX register cannot hold a load, so a bubble never re-stalls.
    a_bubble_no_stall: assert property (@(posedge CLK) disable iff (!RST)
        !((state_q == BUBBLE) && lwstall));
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_unit;
    logic clk;
    logic rst_n;

    hazard_unit_if #(.REG_W(5), .CNT_W(4)) hif ();

    hazard_unit #(.REG_W(5), .CNT_W(4)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (hif.slave)
    );

    typedef struct {
        string      nm;
        logic       st;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "stall", {5'b0, hif.STALLF, hif.STALLD, hif.FLUSHE}, {5'b0, {3{e.st}}});
            cmp(e.nm, "fwdA", {6'b0, hif.FORWARDAE}, {6'b0, e.fa});
            cmp(e.nm, "fwdB", {6'b0, hif.FORWARDBE}, {6'b0, e.fb});
            cmp(e.nm, "cnt", {4'b0, hif.STALLCNT}, {4'b0, e.cnt});
        end
    end

    task automatic drv(input logic [4:0] rsd, rtd, rse, rte, input logic we, me, input logic [4:0] wa);
        hif.rsD = rsd; hif.rtD = rtd; hif.rsE = rse; hif.rtE = rte;
        hif.WRITEREGE = we; hif.MEMTOREGE = me; hif.WRITEADDRE = wa;
    endtask

    task automatic ex(input string nm, input logic st, input logic [1:0] fa, fb, input logic [3:0] cnt);
        exp_t e;
        e.nm = nm; e.st = st; e.fa = fa; e.fb = fb; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 3, 3, 0, 0, 0);
        tick();
        ex("reset", 0, 2'b00, 2'b00, 0);
        tick();
        rst_n = 1'b1;

        // load-use: lw $8 in E, rsD = 8
        drv(8, 0, 0, 0, 1, 1, 8);          ex("lu_stall",   1, 2'b00, 2'b00, 0); tick();
        drv(8, 0, 8, 0, 0, 0, 0);          ex("lu_memgate", 0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 8, 0, 1, 0, 10);         ex("lu_wbfwd",   0, 2'b01, 2'b00, 1); tick();

        // M/W priority on $5
        drv(0, 0, 0, 0, 1, 0, 5);          ex("pr_setup",   0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 10, 10, 1, 0, 5);        ex("pr_w10",     0, 2'b01, 2'b01, 1); tick();
        drv(0, 0, 5, 5, 0, 0, 0);          ex("pr_mwins",   0, 2'b10, 2'b10, 1); tick();
        drv(0, 0, 5, 5, 0, 0, 0);          ex("pr_wonly",   0, 2'b01, 2'b01, 1); tick();

        // register zero never stalls or forwards
        drv(0, 0, 0, 0, 1, 1, 0);          ex("z_nostall",  0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 0, 0, 1, 0, 0);          ex("z_m_load",   0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0);          ex("z_m_alu",    0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0);          ex("z_w",        0, 2'b00, 2'b00, 1); tick();

        // ALU producer of $9 consumed via rt
        drv(0, 9, 0, 0, 1, 0, 9);          ex("alu_nostall",0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 0, 9, 0, 0, 0);          ex("alu_fwdM",   0, 2'b00, 2'b10, 1); tick();
        drv(0, 0, 0, 9, 0, 0, 0);          ex("alu_fwdW",   0, 2'b00, 2'b01, 1); tick();

        // near misses: different register, load without write enable
        drv(9, 7, 0, 0, 1, 1, 8);          ex("nm_reg",     0, 2'b00, 2'b00, 1); tick();
        drv(8, 8, 0, 0, 0, 1, 8);          ex("nm_nowe",    0, 2'b00, 2'b00, 1); tick();

        // reset with a pending M forward
        drv(0, 0, 0, 0, 1, 0, 3);          ex("rm_setup",   0, 2'b00, 2'b00, 1); tick();
        drv(0, 0, 3, 0, 0, 0, 0);          ex("rm_fwd",     0, 2'b10, 2'b00, 1);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        ex("rm_reset", 0, 2'b00, 2'b00, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        tick();

        // saturation: 20 load-use stalls, alternating rs/rt dependence
        for (int i = 0; i < 20; i++) begin
            logic [4:0] wa;
            wa = 5'((i % 30) + 1);
            if (i % 2 == 0) drv(wa, 0, 0, 0, 1, 1, wa);
            else            drv(0, wa, 0, 0, 1, 1, wa);
            ex("sat_stall", 1, 2'b00, 2'b00, 4'((i < 15) ? i : 15));
            tick();
            drv(hif.rsD, hif.rtD, 0, 0, 0, 0, 0);
            ex("sat_bubble", 0, 2'b00, 2'b00, 4'((i + 1 < 15) ? i + 1 : 15));
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        ex("sat_hold", 0, 2'b00, 2'b00, 15);
        tick();
        @(negedge clk); #1;

        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
